hc595_chain_ctrl: RTL

Parametrised serial driver for a daisy-chain of 74HC595 shift registers feeding the digital-tube segment/select lines. It accepts a DATA_W-bit parallel word through a valid/ready handshake, shifts it out on DS/SHCP at a programmable rate, pulses STCP to latch it, and controls the chain's output enable. It sits between the display scan/decode logic and the board pins, and supersedes the fixed 14-bit, fixed-rate controller.

---
 rtl/hc595_chain_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hc595_chain_ctrl.sv
// Serial driver for a daisy-chain of 74HC595s: handshake load, DS/SHCP shift, STCP latch, OE control.
// Optional HC595_PWM_EN adds a dim input and PWM on oe_n after the first latch.
module hc595_chain_ctrl #(
    parameter int DATA_W    = 14,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              ds,
    output logic              shcp,
    output logic              stcp,
    output logic              oe_n,
    output logic              busy,
    output logic              done
`ifdef HC595_PWM_EN
    ,
    input  logic [7:0]        dim
`endif
);

    localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAT  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] ALL_BITS = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] sreg;
    logic [DIV_W-1:0]  div;
    logic [CNT_W-1:0]  bit_cnt;
    logic              latched;
    logic              next_bit;

    assign load_ready = (state == IDLE);
    assign next_bit   = MSB_FIRST ? sreg[DATA_W-1] : sreg[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sreg    <= '0;
            div     <= '0;
            bit_cnt <= '0;
            latched <= 1'b0;
            ds      <= 1'b0;
            shcp    <= 1'b0;
            stcp    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done    <= 1'b0;
            latched <= latched | done;
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (load_valid) begin
                        sreg    <= data_in;
                        // Preloaded to end-of-bit so the next edge starts bit 0.
                        div     <= DIV_END;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    busy <= 1'b1;
                    if (div == DIV_END) begin
                        div  <= '0;
                        shcp <= 1'b0;
                        if (bit_cnt == ALL_BITS) begin
                            stcp  <= 1'b1;
                            state <= LATCH;
                        end else begin
                            ds      <= next_bit;
                            sreg    <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div <= div + 1'b1;
                        if (div + 1'b1 == DIV_HALF) begin
                            shcp <= 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (div == DIV_LAT) begin
                        stcp  <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HC595_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt <= '0;
            oe_n    <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            oe_n    <= (latched | done) ? (pwm_cnt >= dim) : 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oe_n <= 1'b1;
        end else begin
            oe_n <= ~(latched | done);
        end
    end
`endif

endmodule
